pmod_dac_sequencer: RTL
=======================

Name: pmod_dac_sequencer

Overview:
Upstream feeder for the PMOD DAC block. The SoC writes samples into a small synchronous FIFO. The sequencer pops one sample per programmable sample period and drives the DAC block's din/load_din/start inputs. Start is stretched so the DAC block's slow_clk domain always samples it, and the period is clamped so a new frame never begins before the previous DAC frame completes.

Parameters:
RESOLUTION, 16, sample width (matches DAC block)
FIFO_DEPTH, 16, sample FIFO entries; power of 2, ≥2
PERIOD_WIDTH, 16, width of sample_period
START_HOLD, 25, clk cycles dac_start held high; covers ≥2 slow_clk periods
MIN_PERIOD, 250, lower clamp on effective period in clk cycles; covers one full DAC frame; must be ≥ START_HOLD+2

Ports:
clk  in  1  system clock (same clk as DAC block)
rst  in  1  synchronous, active-high reset
wr_en  in  1  SoC sample write strobe
wr_data  in  RESOLUTION  sample to enqueue
enable  in  1  level; run sequencing while high
sample_period  in  PERIOD_WIDTH  clk cycles between successive pops
clr_status  in  1  one-cycle pulse; clears sticky flags
dac_din  out  RESOLUTION  registered sample to DAC block din
dac_load_din  out  1  one-cycle load strobe to DAC block
dac_start  out  1  stretched start to DAC block
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
fifo_full  out  1  count == FIFO_DEPTH
fifo_empty  out  1  count == 0
underflow  out  1  sticky: period expired with enable high and FIFO empty
overflow  out  1  sticky: write dropped
busy  out  1  state != IDLE

Behaviour:
- Reset: FIFO emptied. dac_din=0, dac_load_din=0, dac_start=0, underflow=0, overflow=0, busy=0, fifo_empty=1, fifo_full=0, fifo_count=0. Counters=0, state=IDLE. Reset mid-frame: dac_start drops at the next edge.
- All outputs are registered.
- eff_period = max(sample_period, MIN_PERIOD); sampled at each pop and held for that frame.
- States: IDLE, LOAD, START, WAIT.
- IDLE, cycle t, with enable=1 and !empty:
  - Pop the FIFO head into dac_din (valid at t+1).
  - Clear the period counter to 0.
  - Go to LOAD.
- LOAD (t+1): dac_load_din=1 for exactly this cycle; go to START.
- START (t+2 .. t+1+START_HOLD): dac_start=1 for exactly START_HOLD cycles; then go to WAIT.
- WAIT: the period counter has counted every cycle since the pop. When counter == eff_period-1:
  - enable & !empty: pop again; go to LOAD. Consecutive pops are exactly eff_period cycles apart.
  - enable & empty: set underflow; go to IDLE. No frame is issued and dac_din holds its last value.
  - !enable: go to IDLE.
- enable deasserted during LOAD/START: the frame completes (start is never truncated), then WAIT runs its period and the block goes to IDLE. A new pop never occurs before eff_period has elapsed.
- FIFO write rules:
  - wr_en accepted when !full.
  - When full, wr_en is still accepted if a pop occurs in the same cycle; count is unchanged.
  - When full with no pop, the write is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
  - No read-through: a write into an empty FIFO is poppable the next cycle at the earliest.
- clr_status clears both sticky flags. A flag-setting event in the same cycle wins and the flag stays 1.
- sample_period changes take effect at the next pop only.

Decomposition:
- Package pmod_dac_pkg: sequencer state encoding (2-bit IDLE=0, LOAD=1, START=2, WAIT=3) and the default START_HOLD/MIN_PERIOD constants. The DAC block and its benches reuse these.
- Sub-module sample_fifo: synchronous FIFO, parameterised by width/depth, with wr_en, rd_en, rd_data (registered), count, full, empty. The sequencer owns the FSM, period counter, start stretcher and sticky flags.

Test Plan:
- Basic frame: write 0x1234, sample_period=300, enable=1. Expect dac_din=0x1234 with dac_load_din high one cycle one cycle after the pop, then dac_start high exactly 25 cycles. fifo_empty returns to 1 and busy=0 300 cycles after the pop.
- Period clamp and cadence: write 4 samples (0x0001..0x0004), sample_period=10. Expect load strobes exactly 250 cycles apart, samples in order. After the 4th frame: underflow=1, IDLE.
- Overflow/wrap: write 17 samples back-to-back with enable=0. Expect fifo_full=1 after 16, overflow=1, count=16. Enable and drain: the 16 samples come out in order and the 17th never appears.
- Full with simultaneous pop: fill 16, enable, and write 0xBEEF on the pop cycle. Expect the write accepted, count stays 16, overflow=0, and 0xBEEF is eventually output last.
- Mid-frame events: deassert enable during START. Expect dac_start still 25 cycles and no further pop. Assert rst during START. Expect dac_start=0 and fifo_count=0 at the next edge. Assert clr_status coincident with an underflow event. Expect underflow=1.

Source files
------------

// File: rtl/pmod_dac_pkg.sv
// Shared definitions for the PMOD DAC path: sequencer state encoding and default
// timing constants, reused by the DAC block and its benches.
package pmod_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } seq_state_t;

    localparam int DEFAULT_START_HOLD = 25;
    localparam int DEFAULT_MIN_PERIOD = 250;

endpackage

// File: rtl/pmod_dac_sequencer_sample_fifo.sv
// Synchronous sample FIFO with registered read data, count and flags.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;
    logic [CW-1:0]    count_next;

    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Flags are registered from the next count so no read-through is possible.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/pmod_dac_sequencer.sv
// Pops one FIFO sample per clamped sample period and drives the DAC block's
// din/load_din/start, stretching start so the slow DAC clock always sees it.
module pmod_dac_sequencer
    import pmod_dac_pkg::*;
#(
    parameter int RESOLUTION   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int START_HOLD   = DEFAULT_START_HOLD,
    parameter int MIN_PERIOD   = DEFAULT_MIN_PERIOD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [RESOLUTION-1:0]         wr_data,
    input  logic                          enable,
    input  logic [PERIOD_WIDTH-1:0]       sample_period,
    input  logic                          clr_status,
    output logic [RESOLUTION-1:0]         dac_din,
    output logic                          dac_load_din,
    output logic                          dac_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          underflow,
    output logic                          overflow,
    output logic                          busy
);

    localparam int HW = $clog2(START_HOLD + 1);
    localparam logic [PERIOD_WIDTH-1:0] MIN_P     = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [HW-1:0]           HOLD_LAST = HW'(START_HOLD - 1);

    seq_state_t              state;
    seq_state_t              next_state;
    logic [PERIOD_WIDTH-1:0] period_cnt;
    logic [PERIOD_WIDTH-1:0] eff_period;
    logic [PERIOD_WIDTH-1:0] clamped_period;
    logic [HW-1:0]           hold_cnt;
    logic                    period_done;
    logic                    pop;
    logic                    underflow_set;
    logic                    overflow_set;

    sample_fifo #(
        .WIDTH (RESOLUTION),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (dac_din),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign clamped_period = (sample_period < MIN_P) ? MIN_P : sample_period;
    assign period_done    = (period_cnt == eff_period - PERIOD_WIDTH'(1));
    assign overflow_set   = wr_en && fifo_full && !pop;

    always_comb begin
        next_state    = state;
        pop           = 1'b0;
        underflow_set = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    pop        = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = START;
            end
            START: begin
                if (hold_cnt == HOLD_LAST) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (period_done) begin
                    if (enable && !fifo_empty) begin
                        pop        = 1'b1;
                        next_state = LOAD;
                    end else begin
                        underflow_set = enable;
                        next_state    = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Strobes and busy are registered from next_state so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            period_cnt   <= '0;
            eff_period   <= MIN_P;
            hold_cnt     <= '0;
            dac_load_din <= 1'b0;
            dac_start    <= 1'b0;
            busy         <= 1'b0;
            underflow    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= next_state;
            dac_load_din <= (next_state == LOAD);
            dac_start    <= (next_state == START);
            busy         <= (next_state != IDLE);
            if (pop) begin
                period_cnt <= '0;
                eff_period <= clamped_period;
            end else if (state != IDLE) begin
                period_cnt <= period_cnt + PERIOD_WIDTH'(1);
            end
            if (state == START) begin
                hold_cnt <= hold_cnt + HW'(1);
            end else begin
                hold_cnt <= '0;
            end
            underflow <= underflow_set || (underflow && !clr_status);
            overflow  <= overflow_set  || (overflow  && !clr_status);
        end
    end

endmodule
